fir_tap_reload_ctrl: RTL and testbench
======================================

// Module: fir_tap_reload_ctrl
// PURPOSE
// Configuration/sequencing controller in front of one configurable_fir instance. Holds a
// shadow tap bank written by a control port. On commit it quiesces the FIR, pulses its
// enable low, streams all taps into it, then reopens the sample path.
// Sample stream passes through with handshake gating; FIR output goes straight downstream.
// PARAMETERS
// G_TAPS_LOG2   4   log2 total taps T (= FIR N_LOG2+M_LOG2); T = 2**G_TAPS_LOG2
// G_TAP_WIDTH   16  tap width, equals FIR G_TAP_WIDTH
// G_DATA_WIDTH  16  sample width, equals FIR G_DATA_WIDTH
// PORTS
// clk                in   1        clock
// reset              in   1        synchronous, active-high
// cfg_wr_addr        in   TAPS_LOG2 shadow bank write address
// cfg_wr_data        in   TAP_W    shadow bank write data
// cfg_wr_en          in   1        shadow write strobe
// cfg_commit         in   1        request reload of FIR from shadow bank (pulse)
// cfg_busy           out  1        1 in DRAIN/DISABLE/LOAD/WAIT_DONE or commit pending
// cfg_wr_err         out  1        1-cycle pulse: write dropped because cfg_busy=1
// cfg_loaded         out  1        FIR holds a complete tap set, sample path open
// cfg_load_count     out  8        completed reloads, wraps 255->0
// fir_enable         out  1        to FIR enable
// fir_tap_din        out  TAP_W    to FIR tap_din
// fir_tap_din_valid  out  1        to FIR tap_din_valid
// fir_tap_din_ready  in   1        from FIR tap_din_ready
// fir_tap_din_done   in   1        from FIR tap_din_done
// s_din/_valid/_ready  in/in/out  DATA_W/1/1  upstream sample stream
// fir_din/_valid/_ready out/out/in DATA_W/1/1 to FIR sample input
// fir_dout_valid     in   1        observed FIR output valid
// fir_dout_ready     in   1        observed downstream ready
// BEHAVIOUR
// Reset values: fir_enable=0, fir_tap_din_valid=0, fir_din_valid=0, s_din_ready=0,
//   cfg_busy=0, cfg_wr_err=0, cfg_loaded=0, cfg_load_count=0, state=UNCONFIG,
//   outstanding=0, pending=0, load_idx=0. Shadow bank is NOT reset.
// Shadow write: cfg_wr_en & !cfg_busy -> bank[addr]<=data next edge; else cfg_wr_err pulses.
// States:
//  UNCONFIG: fir_enable=0, sample path closed. commit -> DISABLE.
//  RUN: fir_enable=1; fir_din=s_din, fir_din_valid=s_din_valid, s_din_ready=fir_din_ready
//       (combinational). commit or pending -> DRAIN (pending cleared).
//  DRAIN: s_din_ready=0, fir_din_valid=0; wait outstanding==0 -> DISABLE.
//  DISABLE: fir_enable=0 exactly 1 cycle, load_idx<=0 -> LOAD.
//  LOAD: fir_enable=1; fir_tap_din=bank[load_idx] (comb read), fir_tap_din_valid=1.
//       On valid&ready: load_idx++; on handshake with load_idx==T-1 -> WAIT_DONE.
//  WAIT_DONE: fir_tap_din_valid=0; fir_tap_din_done==1 -> RUN, cfg_loaded<=1,
//       cfg_load_count++.
// outstanding: set on fir_din handshake, cleared on fir_dout_valid&fir_dout_ready;
//   both same cycle -> 1.
// Commit in DRAIN/DISABLE/LOAD/WAIT_DONE: pending<=1 (one deep, extra commits merge);
//   serviced on first RUN cycle (RUN holds >=1 cycle, no sample accepted that cycle).
// cfg_loaded cleared on entering DISABLE; stays 0 until WAIT_DONE exit.
// cfg_busy = (state!=RUN && state!=UNCONFIG) | pending.
// FIR first tap ready appears >=1 cycle after fir_enable rises; LOAD must not assume
//   ready in first cycle. Tap handshakes may stall any number of cycles.
// Reset mid-operation: all state/outputs to reset values same edge; fir_enable drops,
//   forcing FIR to its init state; in-flight output abandoned.
// TESTING
// T1 reset, write bank[i]=i+1 (i=0..15), commit -> fir_enable low 1 cycle, 16 taps 1..16
//    in order, cfg_loaded=1, cfg_load_count=1.
// T2 impulse 0x7FFF then 15 zeros via s_din -> FIR outputs follow taps 1..16 scaled.
// T3 commit while sample outstanding, dout_ready held low 20 cycles -> no DISABLE until
//    output accepted; s_din_ready=0 throughout DRAIN.
// T4 cfg_wr_en during LOAD -> cfg_wr_err pulse, bank unchanged; 3 commits during LOAD ->
//    exactly one further reload, cfg_load_count +2 total.
// T5 fir_tap_din_ready random 50% -> all 16 taps delivered once, in order.
// T6 reset asserted at tap 7 of LOAD -> fir_enable=0, cfg_loaded=0, count=0 next cycle.

Source files
------------

// File: rtl/fir_tap_reload_ctrl.sv
// Tap-reload sequencer for a configurable FIR: shadow tap bank, commit-driven
// drain/disable/load/wait-done sequence, and handshake gating of the sample path.
module fir_tap_reload_ctrl #(
  parameter int G_TAPS_LOG2  = 4,
  parameter int G_TAP_WIDTH  = 16,
  parameter int G_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [G_TAPS_LOG2-1:0]  cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]  cfg_wr_data,
  input  logic                    cfg_wr_en,
  input  logic                    cfg_commit,
  output logic                    cfg_busy,
  output logic                    cfg_wr_err,
  output logic                    cfg_loaded,
  output logic [7:0]              cfg_load_count,
  output logic                    fir_enable,
  output logic [G_TAP_WIDTH-1:0]  fir_tap_din,
  output logic                    fir_tap_din_valid,
  input  logic                    fir_tap_din_ready,
  input  logic                    fir_tap_din_done,
  input  logic [G_DATA_WIDTH-1:0] s_din,
  input  logic                    s_din_valid,
  output logic                    s_din_ready,
  output logic [G_DATA_WIDTH-1:0] fir_din,
  output logic                    fir_din_valid,
  input  logic                    fir_din_ready,
  input  logic                    fir_dout_valid,
  input  logic                    fir_dout_ready
);

  localparam int                     T        = 2 ** G_TAPS_LOG2;
  localparam logic [G_TAPS_LOG2-1:0] LAST_IDX = G_TAPS_LOG2'(T - 1);

  typedef enum logic [2:0] {
    ST_UNCONFIG  = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_DISABLE   = 3'd3,
    ST_LOAD      = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic                     pending_q, pending_d;
  logic                     outstanding_q, outstanding_d;
  logic [G_TAPS_LOG2-1:0]   load_idx_q, load_idx_d;
  logic                     loaded_q, loaded_d;
  logic [7:0]               load_count_q, load_count_d;
  logic                     wr_err_q, wr_err_d;
  logic [G_TAP_WIDTH-1:0]   bank_q [T];

  logic busy_s;
  logic bank_we_s;
  logic commit_in_reload_s;
  logic din_hs_s;
  logic dout_hs_s;

  assign busy_s             = ((state_q != ST_RUN) && (state_q != ST_UNCONFIG)) || pending_q;
  assign bank_we_s          = cfg_wr_en && !busy_s;
  assign commit_in_reload_s = cfg_commit && ((state_q == ST_DRAIN) || (state_q == ST_DISABLE) ||
                                             (state_q == ST_LOAD)  || (state_q == ST_WAIT_DONE));
  assign din_hs_s           = fir_din_valid && fir_din_ready;
  assign dout_hs_s          = fir_dout_valid && fir_dout_ready;

  assign cfg_busy       = busy_s;
  assign cfg_wr_err     = wr_err_q;
  assign cfg_loaded     = loaded_q;
  assign cfg_load_count = load_count_q;
  assign fir_din        = s_din;
  assign fir_tap_din    = bank_q[load_idx_q];

  // Next-state, sequencing outputs and sample-path gating
  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q;
    load_idx_d        = load_idx_q;
    loaded_d          = loaded_q;
    load_count_d      = load_count_q;
    fir_enable        = 1'b0;
    fir_tap_din_valid = 1'b0;
    fir_din_valid     = 1'b0;
    s_din_ready       = 1'b0;

    case (state_q)
      ST_UNCONFIG: begin
        if (cfg_commit) begin
          state_d  = ST_DISABLE;
          loaded_d = 1'b0;
        end else begin
          state_d  = ST_UNCONFIG;
        end
      end
      ST_RUN: begin
        fir_enable = 1'b1;
        // A pending commit owns this cycle: the path stays closed so nothing new goes in flight
        if (pending_q) begin
          fir_din_valid = 1'b0;
          s_din_ready   = 1'b0;
        end else begin
          fir_din_valid = s_din_valid;
          s_din_ready   = fir_din_ready;
        end
        if (cfg_commit || pending_q) begin
          state_d   = ST_DRAIN;
          pending_d = 1'b0;
        end else begin
          state_d   = ST_RUN;
        end
      end
      ST_DRAIN: begin
        fir_enable = 1'b1;
        if (!outstanding_q) begin
          state_d  = ST_DISABLE;
          loaded_d = 1'b0;
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      ST_DISABLE: begin
        fir_enable = 1'b0;
        load_idx_d = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        fir_enable        = 1'b1;
        fir_tap_din_valid = 1'b1;
        if (fir_tap_din_ready) begin
          if (load_idx_q == LAST_IDX) begin
            load_idx_d = '0;
            state_d    = ST_WAIT_DONE;
          end else begin
            load_idx_d = load_idx_q + G_TAPS_LOG2'(1);
            state_d    = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WAIT_DONE: begin
        fir_enable = 1'b1;
        if (fir_tap_din_done) begin
          state_d      = ST_RUN;
          loaded_d     = 1'b1;
          load_count_d = load_count_q + 8'd1;
        end else begin
          state_d      = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_UNCONFIG;
      end
    endcase

    // Commits arriving mid-reload collapse into a single queued request
    if (commit_in_reload_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Outstanding-sample flag and dropped-write pulse
  always_comb begin
    outstanding_d = outstanding_q;
    wr_err_d      = cfg_wr_en && busy_s;
    if (din_hs_s) begin
      outstanding_d = 1'b1;
    end else if (dout_hs_s) begin
      outstanding_d = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_UNCONFIG;
      pending_q     <= 1'b0;
      outstanding_q <= 1'b0;
      load_idx_q    <= '0;
      loaded_q      <= 1'b0;
      load_count_q  <= 8'd0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      load_idx_q    <= load_idx_d;
      loaded_q      <= loaded_d;
      load_count_q  <= load_count_d;
      wr_err_q      <= wr_err_d;
    end
  end

  // Shadow tap bank keeps its contents across reset
  always_ff @(posedge clk) begin
    if (bank_we_s) begin
      bank_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

endmodule

// File: tb/tb_fir_tap_reload_ctrl.sv
// Scoreboard bench for fir_tap_reload_ctrl: a behavioural FIR stand-in drives the
// tap/sample handshakes, and a monitor checks delivered taps and samples against queues.
module tb_fir_tap_reload_ctrl;
  localparam int TL = 4;
  localparam int TW = 16;
  localparam int DW = 16;
  localparam int T  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [TL-1:0] cfg_wr_addr = '0;
  logic [TW-1:0] cfg_wr_data = '0;
  logic          cfg_wr_en = 1'b0;
  logic          cfg_commit = 1'b0;
  logic          cfg_busy, cfg_wr_err, cfg_loaded;
  logic [7:0]    cfg_load_count;
  logic          fir_enable;
  logic [TW-1:0] fir_tap_din;
  logic          fir_tap_din_valid;
  logic          fir_tap_din_ready = 1'b0;
  logic          fir_tap_din_done = 1'b0;
  logic [DW-1:0] s_din = '0;
  logic          s_din_valid = 1'b0;
  logic          s_din_ready;
  logic [DW-1:0] fir_din;
  logic          fir_din_valid;
  logic          fir_din_ready = 1'b0;
  logic          fir_dout_valid = 1'b0;
  logic          fir_dout_ready = 1'b0;

  fir_tap_reload_ctrl #(.G_TAPS_LOG2(TL), .G_TAP_WIDTH(TW), .G_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_wr_err(cfg_wr_err),
    .cfg_loaded(cfg_loaded), .cfg_load_count(cfg_load_count),
    .fir_enable(fir_enable), .fir_tap_din(fir_tap_din), .fir_tap_din_valid(fir_tap_din_valid),
    .fir_tap_din_ready(fir_tap_din_ready), .fir_tap_din_done(fir_tap_din_done),
    .s_din(s_din), .s_din_valid(s_din_valid), .s_din_ready(s_din_ready),
    .fir_din(fir_din), .fir_din_valid(fir_din_valid), .fir_din_ready(fir_din_ready),
    .fir_dout_valid(fir_dout_valid), .fir_dout_ready(fir_dout_ready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_tap[$];
  logic [15:0] exp_smp[$];
  logic [15:0] bank_m[T];
  int          taps_seen = 0;
  bit          rmode = 1'b0;
  bit          hold_dout = 1'b0;

  // FIR stand-in state
  bit tap_hs = 1'b0, din_hs = 1'b0, dout_hs = 1'b0, en_prev = 1'b0;
  int tap_cnt = 0, pend_out = 0;
  // Monitor state
  bit en_mon_prev = 1'b0, tracking = 1'b0;
  int low_cnt = 0;
  logic [15:0] e_mon;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIR stand-in: tap ready never in the first enabled cycle, done after 16 taps, one output per sample
  initial begin
    forever begin
      @(negedge clk);
      if (tap_hs) tap_cnt++;
      if (din_hs) pend_out++;
      if (dout_hs && pend_out > 0) pend_out--;
      if (reset || !fir_enable) begin
        tap_cnt  = 0;
        pend_out = 0;
      end
      fir_tap_din_ready = fir_enable && en_prev && (tap_cnt < T) &&
                          (rmode ? ($urandom_range(0, 1) == 1) : 1'b1);
      fir_tap_din_done  = fir_enable && (tap_cnt == T);
      fir_din_ready     = fir_enable;
      fir_dout_valid    = (pend_out > 0);
      fir_dout_ready    = !hold_dout;
      en_prev           = fir_enable;
      #1;
      tap_hs  = !reset && fir_tap_din_valid && fir_tap_din_ready;
      din_hs  = !reset && fir_din_valid && fir_din_ready;
      dout_hs = !reset && fir_dout_valid && fir_dout_ready;
    end
  end

  // Monitor: pops expectations on every tap/sample handshake, checks enable-low pulse width
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (fir_tap_din_valid && fir_tap_din_ready) begin
          taps_seen++;
          if (exp_tap.size() == 0) chk("tap_unexpected", {16'd0, fir_tap_din}, 32'hFFFF_FFFF);
          else begin
            e_mon = exp_tap.pop_front();
            chk("tap_data", {16'd0, fir_tap_din}, {16'd0, e_mon});
          end
        end
        if (fir_din_valid && fir_din_ready) begin
          if (exp_smp.size() == 0) chk("sample_unexpected", {16'd0, fir_din}, 32'hFFFF_FFFF);
          else begin
            e_mon = exp_smp.pop_front();
            chk("sample_data", {16'd0, fir_din}, {16'd0, e_mon});
          end
        end
        if (en_mon_prev && !fir_enable) begin
          tracking = 1'b1;
          low_cnt  = 1;
        end else if (tracking && !fir_enable) begin
          low_cnt++;
        end else if (tracking && fir_enable) begin
          chk("enable_low_cycles", low_cnt, 32'd1);
          tracking = 1'b0;
        end
      end else begin
        tracking = 1'b0;
      end
      en_mon_prev = fir_enable;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [TL-1:0] a, input logic [TW-1:0] d);
    cfg_wr_addr = a;
    cfg_wr_data = d;
    cfg_wr_en   = 1'b1;
    @(negedge clk);
    cfg_wr_en   = 1'b0;
  endtask

  task automatic commit_pulse();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic push_bank();
    for (int i = 0; i < T; i++) exp_tap.push_back(bank_m[i]);
  endtask

  task automatic wait_count(input logic [7:0] tgt, input int bound, input string nm);
    int n = 0;
    #2;
    while (cfg_load_count !== tgt && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(nm, {24'd0, cfg_load_count}, {24'd0, tgt});
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    bit ok = 1'b0;
    exp_smp.push_back(d);
    s_din       = d;
    s_din_valid = 1'b1;
    do begin
      #2;
      ok = s_din_ready;
      @(negedge clk);
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    s_din_valid = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    // Reset values
    repeat (3) @(negedge clk);
    #2;
    chk("rst_fir_enable", fir_enable, 0);
    chk("rst_tap_valid", fir_tap_din_valid, 0);
    chk("rst_fir_din_valid", fir_din_valid, 0);
    chk("rst_s_din_ready", s_din_ready, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_wr_err", cfg_wr_err, 0);
    chk("rst_loaded", cfg_loaded, 0);
    chk("rst_count", cfg_load_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: bank[i]=i+1, first load
    for (int i = 0; i < T; i++) begin
      bank_m[i] = 16'(i + 1);
      wr(TL'(i), bank_m[i]);
    end
    push_bank();
    commit_pulse();
    #2;
    chk("t1_busy_after_commit", cfg_busy, 1);
    chk("t1_disable_low", fir_enable, 0);
    @(negedge clk);
    wait_count(8'd1, 200, "t1_count");
    #2;
    chk("t1_loaded", cfg_loaded, 1);
    chk("t1_busy_idle", cfg_busy, 0);
    chk("t1_taps_left", exp_tap.size(), 0);
    @(negedge clk);

    // T2: impulse then 15 zeros through the open sample path
    send(16'h7FFF);
    for (int i = 0; i < 15; i++) send(16'h0000);
    repeat (4) @(negedge clk);
    chk("t2_samples_left", exp_smp.size(), 0);

    // T3: commit with an output held back downstream
    hold_dout = 1'b1;
    send(16'h1234);
    push_bank();
    commit_pulse();
    s_din       = 16'hBEEF;
    s_din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("t3_drain_s_din_ready", s_din_ready, 0);
      chk("t3_drain_enable", fir_enable, 1);
      chk("t3_drain_busy", cfg_busy, 1);
      @(negedge clk);
    end
    s_din_valid = 1'b0;
    hold_dout   = 1'b0;
    wait_count(8'd2, 200, "t3_count");
    chk("t3_samples_left", exp_smp.size(), 0);

    // T4: write dropped during LOAD, three commits merge into one reload
    for (int i = 0; i < T; i++) begin
      bank_m[i] = 16'h0100 + 16'(i);
      wr(TL'(i), bank_m[i]);
    end
    push_bank();
    push_bank();
    commit_pulse();
    n = 0;
    #2;
    while (!fir_tap_din_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t4_reach_load", fir_tap_din_valid, 1);
    @(negedge clk);
    wr(4'd3, 16'hDEAD);
    #2;
    chk("t4_wr_err_pulse", cfg_wr_err, 1);
    @(negedge clk);
    #2;
    chk("t4_wr_err_clear", cfg_wr_err, 0);
    @(negedge clk);
    commit_pulse();
    @(negedge clk);
    commit_pulse();
    @(negedge clk);
    commit_pulse();
    #2;
    chk("t4_busy_pending", cfg_busy, 1);
    @(negedge clk);
    wait_count(8'd4, 400, "t4_count");
    repeat (20) @(negedge clk);
    #2;
    chk("t4_no_extra_reload", cfg_load_count, 4);
    chk("t4_loaded", cfg_loaded, 1);
    chk("t4_taps_left", exp_tap.size(), 0);
    @(negedge clk);

    // T5: random tap backpressure
    for (int i = 0; i < T; i++) begin
      bank_m[i] = 16'(i) * 16'h1111;
      wr(TL'(i), bank_m[i]);
    end
    rmode = 1'b1;
    push_bank();
    commit_pulse();
    wait_count(8'd5, 600, "t5_count");
    rmode = 1'b0;
    chk("t5_taps_left", exp_tap.size(), 0);

    // T6: reset in the middle of LOAD, then reload from the preserved bank
    push_bank();
    base = taps_seen;
    commit_pulse();
    n = 0;
    while (taps_seen < base + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_tap7", (taps_seen >= base + 7), 1);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("t6_enable", fir_enable, 0);
    chk("t6_loaded", cfg_loaded, 0);
    chk("t6_count", cfg_load_count, 0);
    chk("t6_tap_valid", fir_tap_din_valid, 0);
    chk("t6_busy", cfg_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_tap.delete();
    push_bank();
    commit_pulse();
    wait_count(8'd1, 200, "t6_recover_count");
    #2;
    chk("t6_recover_loaded", cfg_loaded, 1);
    chk("t6_taps_left", exp_tap.size(), 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
